// File: rtl/sha_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sha_mem_responder
//  Purpose  : Word-addressed memory on the far side of the SHA-256 engine
//             memory port. The engine reads with 1-cycle latency and writes
//             every cycle mem_we is high. A second host port preloads message
//             words and dumps results. A write monitor records which of the
//             8 hash words have landed in the output window.
//  Ports    : clk, reset_n (sync, active-low)
//             engine : mem_we, mem_addr, mem_write_data -> mem_read_data
//             host   : host_req, host_we, host_addr, host_wdata
//                      -> host_gnt (comb), host_rdata, host_rvalid
//             monitor: out_base, clear -> result_mask, result_ready, oor_err
//  Revision : 1.0  initial release
// ============================================================================
module sha_mem_responder #(
    parameter int    DEPTH     = 16384,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_gnt,
    output logic [31:0] host_rdata,
    output logic        host_rvalid,
    input  logic [15:0] out_base,
    input  logic        clear,
    output logic [7:0]  result_mask,
    output logic        result_ready,
    output logic        oor_err
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]     r_mem [0:DEPTH-1];

    logic            w_eng_in;
    logic            w_host_in;
    logic            w_host_acc;
    logic [c_AW-1:0] w_eng_idx;
    logic [c_AW-1:0] w_host_idx;
    logic [16:0]     w_off;
    logic            w_hit;
    logic            w_oor_now;

    // Range checks are done on the full 16-bit address so that DEPTH values
    // that are not powers of two still reject the upper addresses.
    assign w_eng_in   = (32'(mem_addr)  < DEPTH);
    assign w_host_in  = (32'(host_addr) < DEPTH);
    assign w_eng_idx  = mem_addr[c_AW-1:0];
    assign w_host_idx = host_addr[c_AW-1:0];

    // The engine wins a write-write collision on the same word; the host
    // holds its request and is granted once the engine moves on.
    assign host_gnt   = !(host_req && host_we && mem_we && (host_addr == mem_addr));
    assign w_host_acc = host_req && host_gnt;

    // The engine port is always active, so its address is checked every
    // cycle; the host counts only when its access is accepted.
    assign w_oor_now  = !w_eng_in || (w_host_acc && !w_host_in);

    // 17-bit offset: a window that runs past 16'hFFFF simply has no upper
    // words, since mem_addr can never reach them.
    assign w_off = {1'b0, mem_addr} - {1'b0, out_base};
    assign w_hit = mem_we && (mem_addr >= out_base) && (w_off < 17'd8);

    // Storage: no reset on the array. Both ports may write in one cycle;
    // a same-address double write cannot happen because the host is not
    // granted in that case.
    always_ff @(posedge clk) begin
        if (mem_we && w_eng_in) begin
            r_mem[w_eng_idx] <= mem_write_data;
        end
        if (w_host_acc && host_we && w_host_in) begin
            r_mem[w_host_idx] <= host_wdata;
        end
    end

    // Read paths: non-blocking updates give read-before-write on both ports.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_read_data <= 32'h0;
            host_rdata    <= 32'h0;
            host_rvalid   <= 1'b0;
        end else begin
            mem_read_data <= w_eng_in ? r_mem[w_eng_idx] : 32'h0;
            host_rvalid   <= w_host_acc && !host_we;
            if (w_host_acc && !host_we) begin
                host_rdata <= w_host_in ? r_mem[w_host_idx] : 32'h0;
            end
        end
    end

    // Monitor and error state; clear beats a same-cycle set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result_mask  <= 8'h00;
            result_ready <= 1'b0;
            oor_err      <= 1'b0;
        end else if (clear) begin
            result_mask  <= 8'h00;
            result_ready <= 1'b0;
            oor_err      <= 1'b0;
        end else begin
            if (w_hit) begin
                result_mask <= result_mask | (8'b1 << w_off[2:0]);
            end
            // Follows the mask one cycle later.
            result_ready <= (result_mask == 8'hFF);
            if (w_oor_now) begin
                oor_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha_mem_responder
//  Purpose  : Self-checking bench for sha_mem_responder. Directed scenarios
//             followed by randomized traffic, all checked against a
//             behavioural model of memory contents and monitor state.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sha_mem_responder;

    localparam int c_DEPTH = 16384;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = 16'h0;
    logic [31:0] mem_write_data = 32'h0;
    logic [31:0] mem_read_data;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [15:0] host_addr = 16'h0;
    logic [31:0] host_wdata = 32'h0;
    logic        host_gnt;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic [15:0] out_base = 16'h0;
    logic        clear = 1'b0;
    logic [7:0]  result_mask;
    logic        result_ready;
    logic        oor_err;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [31:0] mdl [int];
    bit          seen [8];
    bit          m_ready = 1'b0;
    bit          m_oor = 1'b0;

    always #5 clk = ~clk;

    sha_mem_responder #(.DEPTH(c_DEPTH), .INIT_FILE("")) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid),
        .out_base(out_base), .clear(clear), .result_mask(result_mask),
        .result_ready(result_ready), .oor_err(oor_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mask_of_seen();
        logic [7:0] m = 8'h0;
        for (int i = 0; i < 8; i++) if (seen[i]) m = m | (8'h1 << i);
        return m;
    endfunction

    task automatic eng(input bit we, input logic [15:0] a, input logic [31:0] d);
        mem_we = we; mem_addr = a; mem_write_data = d;
    endtask

    task automatic host(input bit req, input bit we, input logic [15:0] a, input logic [31:0] d);
        host_req = req; host_we = we; host_addr = a; host_wdata = d;
    endtask

    // One clock: checks the grant, predicts every registered output from the
    // model, advances the model, then compares after the edge.
    task automatic cycle();
        bit          exp_gnt, acc, full_before, eng_in, host_in;
        bit          chk_mrd, chk_hrd, exp_rv;
        logic [31:0] exp_mrd, exp_hrd;
        int          off;
        #1;
        exp_gnt = !(host_req && host_we && mem_we && (host_addr == mem_addr));
        chk("host_gnt", {31'b0, host_gnt}, {31'b0, exp_gnt});
        acc     = host_req && exp_gnt;
        eng_in  = (int'(mem_addr)  < c_DEPTH);
        host_in = (int'(host_addr) < c_DEPTH);

        chk_mrd = 1'b1; exp_mrd = 32'h0;
        if (eng_in) begin
            if (mdl.exists(int'(mem_addr))) exp_mrd = mdl[int'(mem_addr)];
            else chk_mrd = 1'b0;
        end
        exp_rv = acc && !host_we;
        chk_hrd = exp_rv; exp_hrd = 32'h0;
        if (exp_rv && host_in) begin
            if (mdl.exists(int'(host_addr))) exp_hrd = mdl[int'(host_addr)];
            else chk_hrd = 1'b0;
        end

        full_before = (mask_of_seen() == 8'hFF);
        off = int'(mem_addr) - int'(out_base);
        if (!reset_n) begin
            foreach (seen[i]) seen[i] = 1'b0;
            m_ready = 1'b0; m_oor = 1'b0;
            exp_mrd = 32'h0; chk_mrd = 1'b1;
            exp_hrd = 32'h0; chk_hrd = 1'b1; exp_rv = 1'b0;
        end else if (clear) begin
            foreach (seen[i]) seen[i] = 1'b0;
            m_ready = 1'b0; m_oor = 1'b0;
        end else begin
            if (mem_we && off >= 0 && off < 8) seen[off] = 1'b1;
            m_ready = full_before;
            if (!eng_in || (acc && !host_in)) m_oor = 1'b1;
        end
        if (mem_we && eng_in) mdl[int'(mem_addr)] = mem_write_data;
        if (acc && host_we && host_in) mdl[int'(host_addr)] = host_wdata;

        @(posedge clk);
        #1;
        if (chk_mrd) chk("mem_read_data", mem_read_data, exp_mrd);
        if (chk_hrd) chk("host_rdata", host_rdata, exp_hrd);
        chk("host_rvalid", {31'b0, host_rvalid}, {31'b0, exp_rv});
        chk("result_mask", {24'b0, result_mask}, {24'b0, mask_of_seen()});
        chk("result_ready", {31'b0, result_ready}, {31'b0, m_ready});
        chk("oor_err", {31'b0, oor_err}, {31'b0, m_oor});
    endtask

    initial begin
        bit granted;
        int r;
        logic [15:0] a;

        // Reset
        reset_n = 1'b0;
        cycle(); cycle();
        chk("rst_mrd", mem_read_data, 32'h0);
        chk("rst_mask", {24'b0, result_mask}, 32'h0);
        reset_n = 1'b1;

        // Host preload 0x00..0x13, then read 0x05
        for (int i = 0; i < 20; i++) begin
            host(1'b1, 1'b1, 16'(i), 32'hA000_0000 + 32'(i));
            cycle();
        end
        host(1'b1, 1'b0, 16'h0005, 32'h0);
        cycle();
        chk("host_rd5", host_rdata, 32'hA000_0005);
        chk("host_rv5", {31'b0, host_rvalid}, 32'h1);
        host(1'b0, 1'b0, 16'h0, 32'h0);

        // Engine reads 0 then 1 back to back
        eng(1'b0, 16'h0000, 32'h0); cycle();
        chk("eng_rd0", mem_read_data, 32'hA000_0000);
        eng(1'b0, 16'h0001, 32'h0); cycle();
        chk("eng_rd1", mem_read_data, 32'hA000_0001);

        // Output window at 0x0100
        out_base = 16'h0100;
        for (int i = 0; i < 8; i++) begin
            eng(1'b1, 16'h0100 + 16'(i), $urandom);
            cycle();
            chk("mask_step", {24'b0, result_mask}, (32'h1 << (i + 1)) - 32'h1);
        end
        chk("ready_lag", {31'b0, result_ready}, 32'h0);
        eng(1'b0, 16'h0, 32'h0); cycle();
        chk("ready_rise", {31'b0, result_ready}, 32'h1);
        eng(1'b1, 16'h0103, 32'h5); cycle();
        chk("rewrite_mask", {24'b0, result_mask}, 32'hFF);
        eng(1'b0, 16'h0, 32'h0);
        clear = 1'b1; cycle(); clear = 1'b0;
        chk("clear_mask", {24'b0, result_mask}, 32'h0);
        chk("clear_ready", {31'b0, result_ready}, 32'h0);

        // Write-write collision on 0x40
        eng(1'b1, 16'h0040, 32'h1111_1111);
        host(1'b1, 1'b1, 16'h0040, 32'h2222_2222);
        cycle();
        eng(1'b0, 16'h0, 32'h0);
        granted = 1'b0;
        for (int t = 0; t < 4 && !granted; t++) begin
            #1 granted = host_gnt;
            cycle();
        end
        if (!granted) chk("retry_timeout", 32'h0, 32'h1);
        host(1'b1, 1'b0, 16'h0040, 32'h0); cycle();
        chk("coll_rd", host_rdata, 32'h2222_2222);
        host(1'b0, 1'b0, 16'h0, 32'h0);

        // Out-of-range host read
        host(1'b1, 1'b0, 16'h4000, 32'h0); cycle();
        chk("oor_rdata", host_rdata, 32'h0);
        chk("oor_rv", {31'b0, host_rvalid}, 32'h1);
        host(1'b0, 1'b0, 16'h0, 32'h0);
        cycle();
        chk("oor_set", {31'b0, oor_err}, 32'h1);
        cycle(); cycle();
        chk("oor_sticky", {31'b0, oor_err}, 32'h1);
        clear = 1'b1; cycle(); clear = 1'b0;
        chk("oor_clear", {31'b0, oor_err}, 32'h0);

        // Reset in the middle of filling a window
        out_base = 16'h0200;
        for (int i = 0; i < 8; i++) begin
            eng(1'b1, 16'h0200 + 16'(i), $urandom);
            reset_n = (i != 3);
            cycle();
            if (i == 3) begin
                chk("midrst_mask", {24'b0, result_mask}, 32'h0);
                chk("midrst_mrd", mem_read_data, 32'h0);
            end
        end
        reset_n = 1'b1;
        eng(1'b0, 16'h0, 32'h0);
        host(1'b1, 1'b0, 16'h0005, 32'h0); cycle();
        chk("midrst_keep", host_rdata, 32'hA000_0005);
        host(1'b0, 1'b0, 16'h0, 32'h0);

        // Randomized traffic against the model
        out_base = 16'h0300;
        clear = 1'b1; cycle(); clear = 1'b0;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 12)      a = 16'h0020 + 16'($urandom_range(0, 15));
            else if (r < 19) a = 16'h0300 + 16'($urandom_range(0, 9));
            else             a = 16'h4000 + 16'($urandom_range(0, 3));
            eng(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 1) == 0) a = mem_addr;
            else a = 16'h0020 + 16'($urandom_range(0, 15));
            host(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
            clear = ($urandom_range(0, 29) == 0);
            cycle();
        end
        clear = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
